cart_bs_scanner: RTL and testbench
==================================

# cart_bs_scanner

Bank-switch auto-detector and ROM read-port sequencer for the cartridge ROM dual-port RAM. After a cartridge download completes, the block takes port B of the ROM RAM away from the console core, scans the loaded image for bank-switch signatures, and publishes a `force_bs` code. It holds the core in reset while scanning, then returns port B to the core. It sits between the HPS download logic and `A2601top`, replacing the extension-only `force_bs` register.

## Interface

Parameters:
- `MIN_3F`, default 2: number of `85 3F` matches required to select scheme 3F.

Ports:
- `clk_sys` in 1: system clock; also clocks ROM port B.
- `reset` in 1: synchronous, active-high.
- `download` in 1: ioctl download active.
- `rom_size` in 17: loaded byte count, sampled on the falling edge of `download`.
- `ext_bs` in 3: scheme forced by file extension (0 = none), sampled on the rising edge of `download`.
- `core_addr` in 16: ROM address from the core.
- `rom_q` in 8: ROM port B data, 1-cycle registered read latency.
- `rom_addr` out 16: ROM port B address (muxed).
- `bs_out` out 3: scheme code (0 auto, 3 FE, 4 E0, 5 3F, 7 P2), held until the next download.
- `busy` out 1: high during LOAD and SCAN; the top level ORs it into the core reset.
- `done` out 1: single-cycle pulse when the result is valid.

## Operation

States are IDLE, LOAD, SCAN and DONE.
- **IDLE**: `rom_addr = core_addr`; `busy = 0`.
- **Any state, `download` rising edge**: latch `ext_bs`, clear `bs_out` to 0, go to LOAD. A download that restarts mid-SCAN aborts the scan, with no `done` pulse.
- **LOAD**: `busy = 1`; `rom_addr = core_addr`. On the `download` falling edge, latch `rom_size` into `size_r`:
  - If `ext_bs != 0` or `size_r == 0`, go to DONE without scanning; `bs_out = ext_bs`.
  - Otherwise go to SCAN.
- **SCAN**: `rom_addr = scan_addr`.
  - `scan_addr` starts at 0 and increments every cycle until it reaches `size_r - 1`, then holds.
  - Sizes above 65536 cannot occur: the top bit of 17 only encodes 65536.
  - A valid bit `vld` follows the address by 1 cycle.
  - When `vld` is set, shift `rom_q` into a 3-byte window `{w2,w1,w0}`, with newest in `w0`.
  - The window clears to `00 00 00` on SCAN entry.
  - Match counters are 2-bit and saturate at 3; each is tested on the window value after the shift:
    - `c3f` increments when `w1,w0 = 85 3F`.
    - `ce0` increments when `w2,w1,w0` equals `8D E0 1F`, `8D E0 5F`, `8D E9 FF` or `AD E9 FF`.
    - `cfe` increments when `w2,w1,w0 = 20 00 D0`.
  - SCAN ends after byte `size_r - 1` has been shifted.
- **Decision**, in priority order:
  1. `ce0 >= 1` and `size_r == 8192` gives 4.
  2. `cfe >= 1` and `size_r == 8192` gives 3.
  3. `c3f >= MIN_3F` and `size_r > 4096` gives 5.
  4. Otherwise 0.
- **DONE**: for one cycle, `bs_out` takes its final value, `done = 1` and `busy = 0`; `rom_addr = core_addr`. Next state is IDLE.
- **Reset**: state IDLE, `bs_out = 0`, `busy = 0`, `done = 0`, counters and window cleared, `ext_bs` latch 0.

## Timing

- SCAN is entered the cycle after the `download` falling edge (cycle 0). Byte *i* is addressed in cycle *i* and shifted in cycle *i+1*.
- For N = `size_r`, DONE is cycle N+1: `done` is high, `busy` is low, and `bs_out` is valid in that cycle.
- In the skip path, DONE is the cycle after the falling edge.
- `busy` is registered. It rises the cycle after the `download` rising edge and falls when DONE is entered.
- The `rom_addr` mux is combinational from state. The core is in reset throughout SCAN, so it never sees scan data.
- Simultaneous `reset` and `download` edge: reset wins.

## Test plan

- **Forced extension**: `ext_bs = 3`, 8192-byte load → `bs_out = 3` and `done` the cycle after the `download` falling edge; `scan_addr` never leaves 0.
- **3F detection**: 8192-byte image with `85 3F` at offsets 0x100 and 0x900, all other bytes EA → `bs_out = 5`, `done` in cycle 8193 of SCAN, `busy` high until then.
- **E0 priority**: 8192-byte image containing both `8D E0 1F` and `20 00 D0` → `bs_out = 4`. The same image at size 4096 (pattern below 4K) → 0.
- **Window boundary**: pattern `AD E9 FF` as the last 3 bytes of an 8192 image → `bs_out = 4`. A pattern that only wraps around from end to address 0 → 0.
- **Abort**: `download` rises again at SCAN cycle 100 → no `done`, `bs_out = 0`, `busy` stays high, and the new load is scanned normally.
- **Reset mid-SCAN**: `reset` at SCAN cycle 50 → next cycle `busy = 0`, `bs_out = 0`, `rom_addr = core_addr`.

Source files
------------

// File: rtl/cart_bs_scanner.sv
// ----------------------------------------------------------------------------
// cart_bs_scanner
//
// Bank-switch auto-detector and ROM port-B sequencer. After a cartridge
// download finishes, it takes over ROM port B, streams the loaded image
// through a 3-byte window looking for bank-switch signatures, and publishes a
// scheme code. The console core is held in reset (via busy) while scanning.
//
// Ports:
//   clk_sys    in   system clock (also clocks ROM port B)
//   reset      in   synchronous, active-high reset
//   download   in   ioctl download active
//   rom_size   in   loaded byte count, sampled on download falling edge
//   ext_bs     in   scheme forced by file extension (0 = none), sampled on
//                   download rising edge
//   core_addr  in   ROM address from the console core
//   rom_q      in   ROM port B read data, one-cycle registered latency
//   rom_addr   out  ROM port B address (core or scanner)
//   bs_out     out  scheme code: 0 auto, 3 FE, 4 E0, 5 3F, 7 P2
//   busy       out  high while loading/scanning; ORed into core reset
//   done       out  one-cycle pulse when bs_out is final
// ----------------------------------------------------------------------------
module cart_bs_scanner #(
    parameter int unsigned MIN_3F = 2
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        download,
    input  logic [16:0] rom_size,
    input  logic [2:0]  ext_bs,
    input  logic [15:0] core_addr,
    input  logic [7:0]  rom_q,
    output logic [15:0] rom_addr,
    output logic [2:0]  bs_out,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_SCAN = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        dl_q;
    logic [2:0]  ext_q;
    logic [16:0] size_q;
    logic [15:0] scan_addr_q;
    logic        addr_done_q;   // last address has been issued
    logic        vld_q;         // rom_q carries a byte from the scanned range
    logic        last_q;        // that byte is the final one of the image
    logic [7:0]  w2_q, w1_q, w0_q;
    logic [1:0]  c3f_q, ce0_q, cfe_q;
    logic [2:0]  bs_q;
    logic        busy_q;

    logic        dl_rise, dl_fall, skip_scan, at_last;
    logic [23:0] win_shift;
    logic        hit_3f, hit_e0, hit_fe;
    logic [1:0]  c3f_d, ce0_d, cfe_d;
    logic [2:0]  decision;

    always_comb begin
        dl_rise   = download & ~dl_q;
        dl_fall   = ~download & dl_q;
        skip_scan = (ext_q != 3'd0) || (rom_size == 17'd0);
        at_last   = ({1'b0, scan_addr_q} == (size_q - 17'd1));

        // Window as it will look after shifting in the current byte
        win_shift = {w1_q, w0_q, rom_q};
        hit_3f    = (win_shift[15:0] == 16'h853F);
        hit_e0    = (win_shift == 24'h8DE01F) || (win_shift == 24'h8DE05F) ||
                    (win_shift == 24'h8DE9FF) || (win_shift == 24'hADE9FF);
        hit_fe    = (win_shift == 24'h2000D0);

        c3f_d = (vld_q && hit_3f && (c3f_q != 2'd3)) ? c3f_q + 2'd1 : c3f_q;
        ce0_d = (vld_q && hit_e0 && (ce0_q != 2'd3)) ? ce0_q + 2'd1 : ce0_q;
        cfe_d = (vld_q && hit_fe && (cfe_q != 2'd3)) ? cfe_q + 2'd1 : cfe_q;

        // Uses post-shift counters so the final byte counts toward the result
        if ((ce0_d != 2'd0) && (size_q == 17'd8192)) begin
            decision = 3'd4;
        end else if ((cfe_d != 2'd0) && (size_q == 17'd8192)) begin
            decision = 3'd3;
        end else if ((32'(c3f_d) >= MIN_3F) && (size_q > 17'd4096)) begin
            decision = 3'd5;
        end else begin
            decision = 3'd0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_LOAD: begin
                if (dl_fall) begin
                    state_d = skip_scan ? ST_DONE : ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (vld_q && last_q) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A new download always restarts, aborting any scan in progress
        if (dl_rise) begin
            state_d = ST_LOAD;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            dl_q        <= 1'b0;
            ext_q       <= 3'd0;
            size_q      <= 17'd0;
            scan_addr_q <= 16'd0;
            addr_done_q <= 1'b0;
            vld_q       <= 1'b0;
            last_q      <= 1'b0;
            w2_q        <= 8'd0;
            w1_q        <= 8'd0;
            w0_q        <= 8'd0;
            c3f_q       <= 2'd0;
            ce0_q       <= 2'd0;
            cfe_q       <= 2'd0;
            bs_q        <= 3'd0;
            busy_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            dl_q    <= download;
            busy_q  <= (state_d == ST_LOAD) || (state_d == ST_SCAN);

            if (dl_rise) begin
                ext_q <= ext_bs;
                bs_q  <= 3'd0;
            end

            if ((state_q == ST_LOAD) && dl_fall) begin
                size_q <= rom_size;
                if (skip_scan) begin
                    bs_q <= ext_q;
                end
            end

            if ((state_d == ST_SCAN) && (state_q != ST_SCAN)) begin
                scan_addr_q <= 16'd0;
                addr_done_q <= 1'b0;
                vld_q       <= 1'b0;
                last_q      <= 1'b0;
                w2_q        <= 8'd0;
                w1_q        <= 8'd0;
                w0_q        <= 8'd0;
                c3f_q       <= 2'd0;
                ce0_q       <= 2'd0;
                cfe_q       <= 2'd0;
            end else if (state_q == ST_SCAN) begin
                vld_q  <= ~addr_done_q;
                last_q <= ~addr_done_q & at_last;
                if (!addr_done_q) begin
                    if (at_last) begin
                        addr_done_q <= 1'b1;
                    end else begin
                        scan_addr_q <= scan_addr_q + 16'd1;
                    end
                end
                if (vld_q) begin
                    w2_q  <= win_shift[23:16];
                    w1_q  <= win_shift[15:8];
                    w0_q  <= win_shift[7:0];
                    c3f_q <= c3f_d;
                    ce0_q <= ce0_d;
                    cfe_q <= cfe_d;
                end
                if (state_d == ST_DONE) begin
                    bs_q <= decision;
                end
            end
        end
    end

    assign rom_addr = (state_q == ST_SCAN) ? scan_addr_q : core_addr;
    assign bs_out   = bs_q;
    assign busy     = busy_q;
    assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_cart_bs_scanner.sv
module tb_cart_bs_scanner;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        download;
    logic [16:0] rom_size;
    logic [2:0]  ext_bs;
    logic [15:0] core_addr;
    logic [7:0]  rom_q;
    logic [15:0] rom_addr;
    logic [2:0]  bs_out;
    logic        busy;
    logic        done;

    logic [7:0]  mem [0:65535];
    logic [2:0]  exp_q [$];
    int          n_vec = 0;
    int          n_err = 0;

    cart_bs_scanner #(.MIN_3F(2)) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .download (download),
        .rom_size (rom_size),
        .ext_bs   (ext_bs),
        .core_addr(core_addr),
        .rom_q    (rom_q),
        .rom_addr (rom_addr),
        .bs_out   (bs_out),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk_sys = ~clk_sys;

    // ROM port B: one-cycle registered read
    always @(posedge clk_sys) rom_q <= mem[rom_addr];

    task automatic tick();
        @(posedge clk_sys);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic fill(input logic [7:0] b);
        for (int i = 0; i < 65536; i++) mem[i] = b;
    endtask

    task automatic poke3(input int a, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2);
        mem[a] = b0;
        mem[a + 1] = b1;
        mem[a + 2] = b2;
    endtask

    task automatic start_load(input logic [2:0] ext);
        download = 1'b1;
        ext_bs   = ext;
        tick();
        chk("busy_rise", busy, 1'b1);
        chk("bs_clear", bs_out, 3'd0);
        ext_bs = 3'd0;
    endtask

    // Ends a download (already high) and waits, bounded, for the done pulse
    task automatic finish_load(input logic [16:0] size, input logic [2:0] expv, input bit skip);
        int   cnt;
        int   n_exp;
        bit   got;
        bit   busy_lo;
        logic [2:0] e;
        repeat (2) tick();
        rom_size = size;
        download = 1'b0;
        exp_q.push_back(expv);
        n_exp   = skip ? 1 : int'(size) + 2;
        cnt     = 0;
        got     = 1'b0;
        busy_lo = 1'b0;
        while (!got && cnt < n_exp + 20) begin
            tick();
            cnt++;
            if (done) begin
                got = 1'b1;
            end else begin
                if (!busy) busy_lo = 1'b1;
                if (cnt == 3 && !skip) chk("scan_addr", rom_addr, 16'd2);
            end
        end
        e = exp_q.pop_front();
        chk("done_seen", got, 1'b1);
        if (got) begin
            chk("done_cycle", cnt, n_exp);
            chk("busy_before_done", busy_lo, 1'b0);
            chk("busy_at_done", busy, 1'b0);
            chk("bs_out", bs_out, e);
            chk("rom_addr_done", rom_addr, core_addr);
            tick();
            chk("done_single", done, 1'b0);
            chk("bs_hold", bs_out, e);
        end
    endtask

    initial begin
        reset     = 1'b1;
        download  = 1'b0;
        rom_size  = 17'd0;
        ext_bs    = 3'd0;
        core_addr = 16'hBEEF;
        fill(8'hEA);
        repeat (3) tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_bs", bs_out, 3'd0);
        chk("rst_addr", rom_addr, 16'hBEEF);
        reset = 1'b0;
        tick();

        // Forced extension skips the scan
        start_load(3'd3);
        finish_load(17'd8192, 3'd3, 1'b1);

        // Zero size with no extension also skips
        start_load(3'd0);
        finish_load(17'd0, 3'd0, 1'b1);

        // 3F: two matches
        fill(8'hEA);
        mem[16'h100] = 8'h85; mem[16'h101] = 8'h3F;
        mem[16'h900] = 8'h85; mem[16'h901] = 8'h3F;
        start_load(3'd0);
        finish_load(17'd8192, 3'd5, 1'b0);
        // Same image but 4096 bytes: size not above 4K
        start_load(3'd0);
        finish_load(17'd4096, 3'd0, 1'b0);
        // Only one match: below threshold
        mem[16'h900] = 8'hEA;
        start_load(3'd0);
        finish_load(17'd8192, 3'd0, 1'b0);

        // E0 has priority over FE
        fill(8'hEA);
        poke3(16'h200, 8'h8D, 8'hE0, 8'h1F);
        poke3(16'h300, 8'h20, 8'h00, 8'hD0);
        start_load(3'd0);
        finish_load(17'd8192, 3'd4, 1'b0);
        start_load(3'd0);
        finish_load(17'd4096, 3'd0, 1'b0);

        // FE alone
        fill(8'hEA);
        poke3(16'h400, 8'h20, 8'h00, 8'hD0);
        start_load(3'd0);
        finish_load(17'd8192, 3'd3, 1'b0);

        // Pattern in the last three bytes
        fill(8'hEA);
        poke3(8189, 8'hAD, 8'hE9, 8'hFF);
        start_load(3'd0);
        finish_load(17'd8192, 3'd4, 1'b0);

        // Pattern only via wrap from end to address 0
        fill(8'hEA);
        mem[8191] = 8'hAD; mem[0] = 8'hE9; mem[1] = 8'hFF;
        start_load(3'd0);
        finish_load(17'd8192, 3'd0, 1'b0);

        // Abort mid-scan, then rescan an E0 image normally
        fill(8'hEA);
        poke3(16'h1000, 8'h8D, 8'hE9, 8'hFF);
        start_load(3'd0);
        repeat (2) tick();
        rom_size = 17'd8192;
        download = 1'b0;
        begin
            bit done_seen = 1'b0;
            repeat (101) begin
                tick();
                if (done) done_seen = 1'b1;
            end
            download = 1'b1;
            tick();
            if (done) done_seen = 1'b1;
            chk("abort_no_done", done_seen, 1'b0);
            chk("abort_busy", busy, 1'b1);
            chk("abort_bs", bs_out, 3'd0);
        end
        finish_load(17'd8192, 3'd4, 1'b0);

        // Reset mid-scan
        start_load(3'd0);
        repeat (2) tick();
        rom_size = 17'd8192;
        download = 1'b0;
        repeat (51) tick();
        chk("pre_rst_addr", rom_addr, 16'd50);
        reset = 1'b1;
        tick();
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_bs", bs_out, 3'd0);
        chk("mid_rst_addr", rom_addr, core_addr);
        reset = 1'b0;
        tick();
        chk("post_rst_done", done, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
